// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs, the pipeline write-enables and flushes,
// and the performance counters. The pipeline side is the master and the controller is the slave.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             use_rs_ID;
  logic             use_rt_ID;
  logic             jump_ID;
  logic             MemRead_EX;
  logic             RegWrite_EX;
  logic [4:0]       WriteReg_EX;
  logic             branch_taken_EX;
  logic             cnt_clear;
  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             stall_active;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs_ID, rt_ID, use_rs_ID, use_rt_ID, jump_ID, MemRead_EX, RegWrite_EX,
           WriteReg_EX, branch_taken_EX, cnt_clear,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_active, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, jump_ID, MemRead_EX, RegWrite_EX,
           WriteReg_EX, branch_taken_EX, cnt_clear,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_active, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and branch/jump squash control for the 5-stage pipeline,
// with saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);
  localparam logic [0:0]       IDLE        = 1'b0;
  localparam logic [0:0]       STALL       = 1'b1;
  localparam logic [2:0]       REMAIN_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam bit               MULTI_STALL = (LOAD_STALL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [2:0]       remain_q, remain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_s;
  logic             pc_write_s;
  logic             if_id_write_s;
  logic             if_id_flush_s;
  logic             id_ex_flush_s;

  // Load-use hazard: a load in EX writes a register the ID instruction reads (r0 never counts).
  assign lu_s = hz.MemRead_EX & hz.RegWrite_EX & (hz.WriteReg_EX != 5'd0) &
                ((hz.use_rs_ID & (hz.rs_ID == hz.WriteReg_EX)) |
                 (hz.use_rt_ID & (hz.rt_ID == hz.WriteReg_EX)));

  // Control outputs and FSM next state; priority is branch > stall/load-use > jump.
  always_comb begin
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    state_d       = state_q;
    remain_d      = remain_q;
    if (hz.branch_taken_EX) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
      state_d       = IDLE;
      remain_d      = 3'd0;
    end else if (state_q == STALL) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_flush_s = 1'b1;
      if (remain_q <= 3'd1) begin
        state_d  = IDLE;
        remain_d = 3'd0;
      end else begin
        remain_d = remain_q - 3'd1;
      end
    end else if (lu_s) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_flush_s = 1'b1;
      if (MULTI_STALL) begin
        state_d  = STALL;
        remain_d = REMAIN_INIT;
      end else begin
        state_d  = IDLE;
        remain_d = 3'd0;
      end
    end else if (hz.jump_ID) begin
      if_id_flush_s = 1'b1;
    end else begin
      if_id_flush_s = 1'b0;
    end
  end

  // Saturating event counters; a clear beats an increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_write_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (if_id_flush_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      remain_q    <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.PC_write     = pc_write_s;
  assign hz.IF_ID_write  = if_id_write_s;
  assign hz.IF_ID_flush  = if_id_flush_s;
  assign hz.ID_EX_flush  = id_ex_flush_s;
  assign hz.stall_active = (state_q == STALL);
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (default, 3-cycle stall, 4-bit counters)
// share one set of inputs; each scenario task checks the instance it targets.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs = 5'd0, rt = 5'd0, wr = 5'd0;
  logic       urs = 1'b0, urt = 1'b0, jmp = 1'b0, mr = 1'b0, rw = 1'b0, br = 1'b0, clr = 1'b0;
  int         total = 0;
  int         bad = 0;

  typedef struct packed {
    logic m; logic r; logic [4:0] w; logic [4:0] s; logic [4:0] t; logic us; logic ut; logic lu;
  } luv_t;

  luv_t vec [8] = '{
    '{1'b1, 1'b1, 5'd8,  5'd8, 5'd0,  1'b1, 1'b0, 1'b1},
    '{1'b1, 1'b1, 5'd8,  5'd0, 5'd8,  1'b0, 1'b1, 1'b1},
    '{1'b1, 1'b1, 5'd8,  5'd8, 5'd0,  1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 5'd8,  5'd8, 5'd8,  1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b0, 5'd8,  5'd8, 5'd8,  1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b1, 5'd31, 5'd3, 5'd31, 1'b1, 1'b1, 1'b1},
    '{1'b1, 1'b1, 5'd5,  5'd6, 5'd7,  1'b1, 1'b1, 1'b0}
  };

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) if_d ();
  hazard_ctrl_if #(.CNT_W(32)) if_s ();
  hazard_ctrl_if #(.CNT_W(4))  if_c ();

  assign if_d.rs_ID = rs; assign if_d.rt_ID = rt; assign if_d.use_rs_ID = urs; assign if_d.use_rt_ID = urt;
  assign if_d.jump_ID = jmp; assign if_d.MemRead_EX = mr; assign if_d.RegWrite_EX = rw;
  assign if_d.WriteReg_EX = wr; assign if_d.branch_taken_EX = br; assign if_d.cnt_clear = clr;
  assign if_s.rs_ID = rs; assign if_s.rt_ID = rt; assign if_s.use_rs_ID = urs; assign if_s.use_rt_ID = urt;
  assign if_s.jump_ID = jmp; assign if_s.MemRead_EX = mr; assign if_s.RegWrite_EX = rw;
  assign if_s.WriteReg_EX = wr; assign if_s.branch_taken_EX = br; assign if_s.cnt_clear = clr;
  assign if_c.rs_ID = rs; assign if_c.rt_ID = rt; assign if_c.use_rs_ID = urs; assign if_c.use_rt_ID = urt;
  assign if_c.jump_ID = jmp; assign if_c.MemRead_EX = mr; assign if_c.RegWrite_EX = rw;
  assign if_c.WriteReg_EX = wr; assign if_c.branch_taken_EX = br; assign if_c.cnt_clear = clr;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u_d (.clk(clk), .reset(reset), .hz(if_d.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) u_s (.clk(clk), .reset(reset), .hz(if_s.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4))  u_c (.clk(clk), .reset(reset), .hz(if_c.slave));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic r, input logic [4:0] w, input logic [4:0] s,
                       input logic [4:0] t, input logic us, input logic ut, input logic j, input logic b);
    mr = m; rw = r; wr = w; rs = s; rt = t; urs = us; urt = ut; jmp = j; br = b;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
  endtask

  task automatic clear_cnt;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    step();
    reset = 1'b1;
    idle();
    #1;
    total++; if (if_d.stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d want=0", if_d.stall_cnt); end
    total++; if (if_d.flush_cnt !== 32'd0) begin bad++; $display("FAIL rst_flush_cnt got=%0d want=0", if_d.flush_cnt); end
    total++; if (if_s.stall_active !== 1'b0) begin bad++; $display("FAIL rst_stall_active got=%b want=0", if_s.stall_active); end
    total++; if (if_c.flush_cnt !== 4'd0) begin bad++; $display("FAIL rst_flush_cnt_c got=%0d want=0", if_c.flush_cnt); end
    total++; if ({if_d.PC_write, if_d.IF_ID_write, if_d.IF_ID_flush, if_d.ID_EX_flush} !== 4'b1100) begin
      bad++; $display("FAIL rst_ctrl got=%b want=1100", {if_d.PC_write, if_d.IF_ID_write, if_d.IF_ID_flush, if_d.ID_EX_flush});
    end
    step();
    total++; if (if_d.stall_cnt !== 32'd0 || if_d.flush_cnt !== 32'd0) begin
      bad++; $display("FAIL rst_idle_cnt got=%0d/%0d want=0/0", if_d.stall_cnt, if_d.flush_cnt);
    end
  endtask

  task automatic test_lu_table;
    for (int i = 0; i < 8; i++) begin
      drive(vec[i].m, vec[i].r, vec[i].w, vec[i].s, vec[i].t, vec[i].us, vec[i].ut, 1'b0, 1'b0);
      #1;
      total++; if (if_d.PC_write !== ~vec[i].lu) begin bad++; $display("FAIL lu_pcw[%0d] got=%b want=%b", i, if_d.PC_write, ~vec[i].lu); end
      total++; if (if_d.ID_EX_flush !== vec[i].lu) begin bad++; $display("FAIL lu_idex[%0d] got=%b want=%b", i, if_d.ID_EX_flush, vec[i].lu); end
    end
    idle();
    step();
  endtask

  task automatic test_load_use_default;
    clear_cnt();
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if ({if_d.PC_write, if_d.IF_ID_write, if_d.IF_ID_flush, if_d.ID_EX_flush} !== 4'b0001) begin
      bad++; $display("FAIL ld_stall got=%b want=0001", {if_d.PC_write, if_d.IF_ID_write, if_d.IF_ID_flush, if_d.ID_EX_flush});
    end
    step();
    drive(1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (if_d.PC_write !== 1'b1 || if_d.ID_EX_flush !== 1'b0) begin
      bad++; $display("FAIL ld_release got=%b%b want=10", if_d.PC_write, if_d.ID_EX_flush);
    end
    total++; if (if_d.stall_cnt !== 32'd1) begin bad++; $display("FAIL ld_stall_cnt got=%0d want=1", if_d.stall_cnt); end
    drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (if_d.PC_write !== 1'b1) begin bad++; $display("FAIL ld_r0_pcw got=%b want=1", if_d.PC_write); end
    step();
    total++; if (if_d.stall_cnt !== 32'd1) begin bad++; $display("FAIL ld_r0_cnt got=%0d want=1", if_d.stall_cnt); end
    idle();
    step(); step(); step();
  endtask

  task automatic test_stall3;
    clear_cnt();
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (if_s.PC_write !== 1'b0 || if_s.stall_active !== 1'b0) begin
      bad++; $display("FAIL s3_c1 got=%b%b want=00", if_s.PC_write, if_s.stall_active);
    end
    step();
    drive(1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if ({if_s.PC_write, if_s.ID_EX_flush, if_s.stall_active} !== 3'b011) begin
      bad++; $display("FAIL s3_c2 got=%b want=011", {if_s.PC_write, if_s.ID_EX_flush, if_s.stall_active});
    end
    step();
    total++; if ({if_s.PC_write, if_s.ID_EX_flush, if_s.stall_active} !== 3'b011) begin
      bad++; $display("FAIL s3_c3 got=%b want=011", {if_s.PC_write, if_s.ID_EX_flush, if_s.stall_active});
    end
    step();
    total++; if ({if_s.PC_write, if_s.ID_EX_flush, if_s.stall_active} !== 3'b100) begin
      bad++; $display("FAIL s3_c4 got=%b want=100", {if_s.PC_write, if_s.ID_EX_flush, if_s.stall_active});
    end
    total++; if (if_s.stall_cnt !== 32'd3) begin bad++; $display("FAIL s3_cnt got=%0d want=3", if_s.stall_cnt); end
    // Second hazard, aborted by a branch in its second stall cycle.
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    total++; if ({if_s.PC_write, if_s.IF_ID_flush, if_s.ID_EX_flush} !== 3'b111) begin
      bad++; $display("FAIL s3_abort got=%b want=111", {if_s.PC_write, if_s.IF_ID_flush, if_s.ID_EX_flush});
    end
    step();
    idle();
    #1;
    total++; if (if_s.stall_active !== 1'b0 || if_s.PC_write !== 1'b1) begin
      bad++; $display("FAIL s3_after_abort got=%b%b want=01", if_s.stall_active, if_s.PC_write);
    end
    total++; if (if_s.stall_cnt !== 32'd4 || if_s.flush_cnt !== 32'd1) begin
      bad++; $display("FAIL s3_abort_cnt got=%0d/%0d want=4/1", if_s.stall_cnt, if_s.flush_cnt);
    end
    // Reset in the middle of a stall.
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    total++; if (if_s.stall_active !== 1'b0 || if_s.PC_write !== 1'b1 || if_s.stall_cnt !== 32'd0) begin
      bad++; $display("FAIL s3_midrst got=%b%b/%0d want=01/0", if_s.stall_active, if_s.PC_write, if_s.stall_cnt);
    end
    step();
  endtask

  task automatic test_priority;
    clear_cnt();
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    total++; if ({if_d.PC_write, if_d.IF_ID_write, if_d.IF_ID_flush, if_d.ID_EX_flush} !== 4'b1111) begin
      bad++; $display("FAIL prio_ctrl got=%b want=1111", {if_d.PC_write, if_d.IF_ID_write, if_d.IF_ID_flush, if_d.ID_EX_flush});
    end
    step();
    idle();
    #1;
    total++; if (if_d.flush_cnt !== 32'd1 || if_d.stall_cnt !== 32'd0) begin
      bad++; $display("FAIL prio_cnt got=%0d/%0d want=1/0", if_d.flush_cnt, if_d.stall_cnt);
    end
    step();
  endtask

  task automatic test_jump_stall;
    clear_cnt();
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (if_s.IF_ID_flush !== 1'b0 || if_s.PC_write !== 1'b0) begin
      bad++; $display("FAIL js_c1 got=%b%b want=00", if_s.IF_ID_flush, if_s.PC_write);
    end
    total++; if (if_d.IF_ID_flush !== 1'b0) begin bad++; $display("FAIL js_d_c1 got=%b want=0", if_d.IF_ID_flush); end
    step();
    drive(1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (if_s.IF_ID_flush !== 1'b0 || if_s.PC_write !== 1'b0) begin
      bad++; $display("FAIL js_c2 got=%b%b want=00", if_s.IF_ID_flush, if_s.PC_write);
    end
    total++; if (if_d.IF_ID_flush !== 1'b1 || if_d.ID_EX_flush !== 1'b0) begin
      bad++; $display("FAIL js_d_c2 got=%b%b want=10", if_d.IF_ID_flush, if_d.ID_EX_flush);
    end
    step();
    total++; if (if_s.IF_ID_flush !== 1'b0) begin bad++; $display("FAIL js_c3 got=%b want=0", if_s.IF_ID_flush); end
    step();
    total++; if (if_s.IF_ID_flush !== 1'b1 || if_s.PC_write !== 1'b1) begin
      bad++; $display("FAIL js_c4 got=%b%b want=11", if_s.IF_ID_flush, if_s.PC_write);
    end
    step();
    idle();
    #1;
    total++; if (if_s.flush_cnt !== 32'd1 || if_s.stall_cnt !== 32'd3) begin
      bad++; $display("FAIL js_cnt got=%0d/%0d want=1/3", if_s.flush_cnt, if_s.stall_cnt);
    end
    step();
  endtask

  task automatic test_counters;
    clear_cnt();
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    total++; if (if_c.stall_cnt !== 4'd15) begin bad++; $display("FAIL cnt_sat got=%0d want=15", if_c.stall_cnt); end
    clr = 1'b1;
    #1;
    total++; if (if_c.PC_write !== 1'b0) begin bad++; $display("FAIL cnt_clr_pcw got=%b want=0", if_c.PC_write); end
    step();
    clr = 1'b0;
    total++; if (if_c.stall_cnt !== 4'd0) begin bad++; $display("FAIL cnt_clr got=%0d want=0", if_c.stall_cnt); end
    step();
    total++; if (if_c.stall_cnt !== 4'd1) begin bad++; $display("FAIL cnt_after_clr got=%0d want=1", if_c.stall_cnt); end
    idle();
    clear_cnt();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) step();
    total++; if (if_c.flush_cnt !== 4'd15 || if_c.stall_cnt !== 4'd0) begin
      bad++; $display("FAIL cnt_flush_sat got=%0d/%0d want=15/0", if_c.flush_cnt, if_c.stall_cnt);
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_lu_table();
    test_load_use_default();
    test_stall3();
    test_priority();
    test_jump_stall();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Consumes the EX-side control outputs of the ID/EX register plus the ID-stage operand fields.
- Drives the write-enables and flushes back into PC, IF/ID and ID/EX: it holds the front end and inserts ID/EX bubbles for load-use hazards, and squashes wrong-path instructions on taken branches and jumps.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.
CNT_W, 32, width of the stall and flush counters.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-low reset: state cleared on a rising clk edge while reset==0
rs_ID  input  5  rs field of the instruction in ID
rt_ID  input  5  rt field of the instruction in ID
use_rs_ID  input  1  ID instruction reads rs
use_rt_ID  input  1  ID instruction reads rt
jump_ID  input  1  jump resolved in ID (PCSrc selects a jump target)
MemRead_EX  input  1  MemRead at the ID/EX register output
RegWrite_EX  input  1  RegWrite at the ID/EX register output
WriteReg_EX  input  5  destination register of the EX instruction, after RegDst selection
branch_taken_EX  input  1  Branch_EX and ALU condition true, resolved in EX
cnt_clear  input  1  synchronous clear of both counters
PC_write  output  1  PC update enable
IF_ID_write  output  1  IF/ID update enable
IF_ID_flush  output  1  IF/ID loads a NOP
ID_EX_flush  output  1  ID/EX loads all-zero control (bubble)
stall_active  output  1  FSM is in STALL
stall_cnt  output  CNT_W  cycles with PC_write==0
flush_cnt  output  CNT_W  cycles with IF_ID_flush==1

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE and remain is cleared to 0.
  - stall_cnt and flush_cnt are cleared to 0.
  - Combinational outputs then read PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_flush=0, stall_active=0.
  - Reset wins over every other input, including mid-stall.
- Hazard term, combinational: lu = MemRead_EX & RegWrite_EX & (WriteReg_EX!=0) & ((use_rs_ID & rs_ID==WriteReg_EX) | (use_rt_ID & rt_ID==WriteReg_EX)).
- FSM states are IDLE and STALL, with a 3-bit down-counter remain.
- All control outputs are combinational from state and inputs, with zero-cycle latency. Priority in any state is branch > load-use > jump.
- Branch (branch_taken_EX=1, any state):
  - IF_ID_flush=1, ID_EX_flush=1, PC_write=1, IF_ID_write=1.
  - Next state is IDLE and remain=0; an in-progress stall is aborted.
  - lu and jump_ID are ignored that cycle.
- IDLE with lu=1 and no branch:
  - PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0.
  - If LOAD_STALL_CYCLES>1: next state STALL, remain=LOAD_STALL_CYCLES-1. Otherwise stay in IDLE.
  - Total bubbles = LOAD_STALL_CYCLES.
- STALL with no branch:
  - Same outputs as the lu case; lu is not re-evaluated.
  - remain decrements each cycle. When remain==1 the next state is IDLE and remain goes to 0.
  - Leaving STALL, lu is evaluated afresh in IDLE. A back-to-back hazard re-enters the stall.
- IDLE with jump_ID=1, no lu, no branch: IF_ID_flush=1, PC_write=1, IF_ID_write=1, ID_EX_flush=0 (exactly one squash).
- A jump held in ID behind a load-use stall produces no flush until the stall ends. The flush then occurs in the first non-stall cycle.
- Otherwise: PC_write=1, IF_ID_write=1, no flushes.
- Counters:
  - stall_cnt increments on each clk where PC_write==0.
  - flush_cnt increments on each clk where IF_ID_flush==1.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clear=1 forces both to 0, with priority over increment. Reset has priority over cnt_clear.
- WriteReg_EX==0 never causes a stall.

Test Plan:
- Reset: hold reset=0 for 2 clk with branch_taken_EX=1 and lu conditions true; release -> counters 0, stall_active=0. The first post-reset cycle with idle inputs shows PC_write=1 and no flushes.
- Load-use, default param: MemRead_EX=1, RegWrite_EX=1, WriteReg_EX=8, rs_ID=8, use_rs_ID=1 for one cycle, then the EX inputs go to a bubble -> exactly 1 cycle of PC_write=0 / ID_EX_flush=1, then stall_cnt=1. Repeat with WriteReg_EX=0 -> no stall.
- LOAD_STALL_CYCLES=3: same hazard -> 3 consecutive stall cycles and stall_active high for cycles 2-3. Then assert branch_taken_EX in stall cycle 2 -> stall aborts, both flushes asserted, IDLE next.
- Priority: lu=1, jump_ID=1, branch_taken_EX=1 in one cycle -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1, flush_cnt+1, stall_cnt unchanged.
- Jump during stall: lu and jump_ID together -> stall first with no IF_ID_flush, then one IF_ID_flush cycle after the stall ends.
- Counters: CNT_W=4, 20 stall cycles -> stall_cnt holds 15. Then cnt_clear=1 during a stall cycle -> 0 next edge.
